// File: rtl/pc_predict_unit_pkg.sv
// Shared next-PC definitions: counter encodings, PC source select, reset vector.
// Pure declarations, no latency. No backpressure.
// Also provides the 2-bit saturating counter update.
package pc_predict_unit_pkg;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    typedef enum logic [1:0] {
        PCSEL_SEQ      = 2'd0,
        PCSEL_PRED     = 2'd1,
        PCSEL_REDIRECT = 2'd2,
        PCSEL_HOLD     = 2'd3
    } pcsel_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h4000_0000;

    function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        res = cnt;
        if (taken && cnt != CNT_ST)
            res = cnt + 2'd1;
        else if (!taken && cnt != CNT_SNT)
            res = cnt - 2'd1;
        return res;
    endfunction

endpackage

// File: rtl/pc_predict_unit_if.sv
// Fetch/resolve bundle between the pipeline (master) and the next-PC unit (slave).
// Wires only, no latency. No backpressure; stall_i is the only hold.
// Signal names match the unit's port list.
interface pc_predict_unit_if #(
    parameter int XLEN = 32
);
    logic            stall_i;
    logic            if_is_branch_i;
    logic [XLEN-1:0] if_branch_target_i;
    logic            ex_branch_valid_i;
    logic [XLEN-1:0] ex_pc_i;
    logic            ex_taken_i;
    logic [XLEN-1:0] ex_target_i;
    logic            ex_pred_taken_i;
    logic            ex_jump_i;
    logic [XLEN-1:0] ex_jump_target_i;
    logic [XLEN-1:0] pc_o;
    logic            pred_taken_o;
    logic            flush_o;

    modport master (
        output stall_i, if_is_branch_i, if_branch_target_i,
               ex_branch_valid_i, ex_pc_i, ex_taken_i, ex_target_i,
               ex_pred_taken_i, ex_jump_i, ex_jump_target_i,
        input  pc_o, pred_taken_o, flush_o
    );

    modport slave (
        input  stall_i, if_is_branch_i, if_branch_target_i,
               ex_branch_valid_i, ex_pc_i, ex_taken_i, ex_target_i,
               ex_pred_taken_i, ex_jump_i, ex_jump_target_i,
        output pc_o, pred_taken_o, flush_o
    );
endinterface

// File: rtl/pc_predict_unit_bht_counter_array.sv
// Direct-mapped table of 2-bit saturating branch counters.
// Read is combinational; update lands on the next clk edge (reads see the old value).
// No backpressure: every upd_vld cycle is applied.
module bht_counter_array
    import pc_predict_unit_pkg::*;
#(
    parameter int         ENTRIES = 16,
    parameter logic [1:0] INIT    = CNT_WNT,
    localparam int        IDX     = $clog2(ENTRIES)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [IDX-1:0] rd_idx,
    output logic [1:0]     rd_cnt,
    input  logic           upd_vld,
    input  logic [IDX-1:0] upd_idx,
    input  logic           upd_taken
);
    logic [1:0] cnt_q [ENTRIES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++)
                cnt_q[i] <= INIT;
        end else if (upd_vld) begin
            cnt_q[upd_idx] <= cnt_next(cnt_q[upd_idx], upd_taken);
        end
    end

    assign rd_cnt = cnt_q[rd_idx];

endmodule

// File: rtl/pc_predict_unit.sv
// Next-PC generator with 2-bit BHT prediction and EX-side redirect/flush.
// Prediction 0 cycles; mispredict penalty 2 cycles; flush_o same cycle as the PC load.
// No backpressure; stall_i holds the PC unless a redirect arrives. Optional PC_PREDICT_STATS_EN adds counters.
module pc_predict_unit
    import pc_predict_unit_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              BHT_ENTRIES  = 16,
    parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [1:0]      CNT_INIT     = CNT_WNT
) (
    input  logic        clk,
    input  logic        rst_n,
    pc_predict_unit_if.slave bus
`ifdef PC_PREDICT_STATS_EN
    ,
    output logic [31:0] stat_branches_o,
    output logic [31:0] stat_mispredicts_o
`endif
);
    localparam int IDX = $clog2(BHT_ENTRIES);

    logic [XLEN-1:0] pc_q, pc_d, redirect_pc;
    logic [IDX-1:0]  rd_idx, upd_idx;
    logic [1:0]      rd_cnt;
    logic            pred_taken, mispredict, redirect;
    pcsel_e          pc_sel;

    assign rd_idx  = pc_q[IDX+1:2];
    assign upd_idx = bus.ex_pc_i[IDX+1:2];

    bht_counter_array #(
        .ENTRIES (BHT_ENTRIES),
        .INIT    (CNT_INIT)
    ) u_bht (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (rd_idx),
        .rd_cnt    (rd_cnt),
        .upd_vld   (bus.ex_branch_valid_i),
        .upd_idx   (upd_idx),
        .upd_taken (bus.ex_taken_i)
    );

    assign pred_taken = bus.if_is_branch_i & rd_cnt[1];
    assign mispredict = bus.ex_branch_valid_i & (bus.ex_taken_i != bus.ex_pred_taken_i);
    assign redirect   = mispredict | bus.ex_jump_i;

    always_comb begin
        pc_sel      = PCSEL_SEQ;
        redirect_pc = bus.ex_jump_target_i;
        if (mispredict)
            redirect_pc = bus.ex_taken_i ? bus.ex_target_i : bus.ex_pc_i + XLEN'(4);
        // Redirect outranks stall: the stalled instruction is younger and gets flushed.
        if (redirect)
            pc_sel = PCSEL_REDIRECT;
        else if (bus.stall_i)
            pc_sel = PCSEL_HOLD;
        else if (pred_taken)
            pc_sel = PCSEL_PRED;
        case (pc_sel)
            PCSEL_REDIRECT: pc_d = redirect_pc;
            PCSEL_HOLD:     pc_d = pc_q;
            PCSEL_PRED:     pc_d = bus.if_branch_target_i;
            default:        pc_d = pc_q + XLEN'(4);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc_q <= RESET_VECTOR;
        else
            pc_q <= pc_d;
    end

    assign bus.pc_o         = pc_q;
    assign bus.pred_taken_o = pred_taken;
    // Reset discards a pending redirect, including its flush.
    assign bus.flush_o      = redirect & rst_n;

`ifdef PC_PREDICT_STATS_EN
    logic [31:0] stat_br_q, stat_mp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            if (bus.ex_branch_valid_i && stat_br_q != 32'hFFFF_FFFF)
                stat_br_q <= stat_br_q + 32'd1;
            if (mispredict && stat_mp_q != 32'hFFFF_FFFF)
                stat_mp_q <= stat_mp_q + 32'd1;
        end
    end

    assign stat_branches_o    = stat_br_q;
    assign stat_mispredicts_o = stat_mp_q;
`endif

    illegal_branch_and_jump: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.ex_branch_valid_i && bus.ex_jump_i));

endmodule

// File: tb/tb_pc_predict_unit.sv
// Scoreboard bench for pc_predict_unit: stimulus queues expected PC/pred/flush per cycle,
// a negedge monitor pops and compares.
module tb_pc_predict_unit;
    localparam logic [31:0] B = 32'h4000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    initial forever #5 clk = ~clk;

    pc_predict_unit_if #(.XLEN(32)) bus ();

`ifdef PC_PREDICT_STATS_EN
    logic [31:0] stat_br, stat_mp;
`endif

    pc_predict_unit #(
        .XLEN         (32),
        .BHT_ENTRIES  (16),
        .RESET_VECTOR (32'h4000_0000),
        .CNT_INIT     (2'b01)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef PC_PREDICT_STATS_EN
        ,
        .stat_branches_o    (stat_br),
        .stat_mispredicts_o (stat_mp)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic        pred;
        logic        flush;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check({e.name, ".pc"},    bus.pc_o,                 e.pc);
            check({e.name, ".pred"},  32'(bus.pred_taken_o),    32'(e.pred));
            check({e.name, ".flush"}, 32'(bus.flush_o),         32'(e.flush));
        end
    end

    task automatic idle();
        bus.stall_i            = 1'b0;
        bus.if_is_branch_i     = 1'b0;
        bus.if_branch_target_i = '0;
        bus.ex_branch_valid_i  = 1'b0;
        bus.ex_pc_i            = '0;
        bus.ex_taken_i         = 1'b0;
        bus.ex_target_i        = '0;
        bus.ex_pred_taken_i    = 1'b0;
        bus.ex_jump_i          = 1'b0;
        bus.ex_jump_target_i   = '0;
    endtask

    task automatic br(input logic [31:0] pc, input logic taken, input logic pred,
                      input logic [31:0] tgt);
        bus.ex_branch_valid_i = 1'b1;
        bus.ex_pc_i           = pc;
        bus.ex_taken_i        = taken;
        bus.ex_pred_taken_i   = pred;
        bus.ex_target_i       = tgt;
    endtask

    task automatic jmp(input logic [31:0] tgt);
        bus.ex_jump_i        = 1'b1;
        bus.ex_jump_target_i = tgt;
    endtask

    task automatic fb(input logic [31:0] tgt);
        bus.if_is_branch_i     = 1'b1;
        bus.if_branch_target_i = tgt;
    endtask

    // Inputs for this cycle are already driven; queue the expected outputs and advance.
    task automatic cyc(input logic [31:0] pc, input logic pred, input logic flush,
                       input string name);
        exp_t e;
        e.pc = pc; e.pred = pred; e.flush = flush; e.name = name;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        exp_t e;
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        cyc(B, 1'b0, 1'b0, "reset");
        rst_n = 1'b1;

        cyc(B,        1'b0, 1'b0, "seq0");
        cyc(B + 'h4,  1'b0, 1'b0, "seq1");
        br(B + 'h10, 1'b1, 1'b1, B + 'h40);  cyc(B + 'h8,  1'b0, 1'b0, "train1");
        br(B + 'h10, 1'b1, 1'b1, B + 'h40);  cyc(B + 'hC,  1'b0, 1'b0, "train2");
        fb(B + 'h40);                        cyc(B + 'h10, 1'b1, 1'b0, "pred_taken");
        br(B + 'h10, 1'b0, 1'b1, B + 'h40);  cyc(B + 'h40, 1'b0, 1'b1, "mp_nt_flush");
        jmp(B + 'h10);                       cyc(B + 'h14, 1'b0, 1'b1, "mp_nt_pc");
        fb(B + 'h40); br(B + 'h10, 1'b0, 1'b0, B + 'h40);
                                             cyc(B + 'h10, 1'b1, 1'b0, "cnt10_old_val");
        jmp(B + 'h10);                       cyc(B + 'h40, 1'b0, 1'b1, "pred_target");
        fb(B + 'h40); br(B + 'h10, 1'b1, 1'b1, B + 'h40);
                                             cyc(B + 'h10, 1'b0, 1'b0, "cnt01_same_idx");
        jmp(B + 'h10);                       cyc(B + 'h14, 1'b0, 1'b1, "nt_seq");
        fb(B + 'h40); br(B + 'h10, 1'b1, 1'b1, B + 'h40);
                                             cyc(B + 'h10, 1'b1, 1'b0, "same_idx_next");
        br(B + 'h10, 1'b1, 1'b1, B + 'h40);  cyc(B + 'h40, 1'b0, 1'b0, "sat_up");
        br(B + 'h10, 1'b0, 1'b0, B + 'h40);  cyc(B + 'h44, 1'b0, 1'b0, "sat_down");
        jmp(B + 'h10);                       cyc(B + 'h48, 1'b0, 1'b1, "jmp");
        fb(B + 'h40);                        cyc(B + 'h10, 1'b1, 1'b0, "sat_check");
        jmp(B + 'h20);                       cyc(B + 'h40, 1'b0, 1'b1, "jmp_stall");
        bus.stall_i = 1'b1;                  cyc(B + 'h20, 1'b0, 1'b0, "stall1");
        bus.stall_i = 1'b1;                  cyc(B + 'h20, 1'b0, 1'b0, "stall2");
        bus.stall_i = 1'b1;                  cyc(B + 'h20, 1'b0, 1'b0, "stall3");
        bus.stall_i = 1'b1; jmp(B + 'h100);  cyc(B + 'h20, 1'b0, 1'b1, "stall_jmp");
        br(B + 'h30, 1'b1, 1'b0, B + 'h200); cyc(B + 'h100, 1'b0, 1'b1, "mp_taken");
        jmp(32'hFFFF_FFFC);                  cyc(B + 'h200, 1'b0, 1'b1, "jmp_top");
        cyc(32'hFFFF_FFFC, 1'b0, 1'b0, "top");
        cyc(32'h0000_0000, 1'b0, 1'b0, "wrap");

`ifdef PC_PREDICT_STATS_EN
        check("stat_branches", stat_br, 32'd9);
        check("stat_mispredicts", stat_mp, 32'd2);
`endif

        // Reset lands between edges while a jump redirect is pending.
        jmp(B + 'h500);
        e.pc = 32'h0000_0004; e.pred = 1'b0; e.flush = 1'b1; e.name = "pre_rst";
        sbq.push_back(e);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.pc", bus.pc_o, B);
        check("async_rst.flush", 32'(bus.flush_o), 32'd0);
`ifdef PC_PREDICT_STATS_EN
        check("rst_stat_branches", stat_br, 32'd0);
        check("rst_stat_mispredicts", stat_mp, 32'd0);
`endif
        @(posedge clk);
        #1;
        cyc(B, 1'b0, 1'b0, "in_rst");
        rst_n = 1'b1;

        cyc(B,        1'b0, 1'b0, "post0");
        cyc(B + 'h4,  1'b0, 1'b0, "post1");
        cyc(B + 'h8,  1'b0, 1'b0, "post2");
        cyc(B + 'hC,  1'b0, 1'b0, "post3");
        fb(B + 'h40); cyc(B + 'h10, 1'b0, 1'b0, "cnt_reset");
        cyc(B + 'h14, 1'b0, 1'b0, "post_seq");

        for (int i = 0; i < 10 && sbq.size() > 0; i++)
            @(negedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
